// File: rtl/acc_fetch_stream.sv
// Wide-word fetch buffer feeding a narrow CGRA input port, with request limiter, clear/drain and sticky errors.
// Optional ACC_FETCH_STATS_EN adds a 32-bit accepted-pop counter (pop_count).
module acc_fetch_stream #(
  parameter int IN_W  = 512,
  parameter int OUT_W = 16,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clear,
  input  logic             available_read,
  output logic             request_read,
  input  logic             data_valid,
  input  logic [IN_W-1:0]  read_data,
  input  logic             pop_data,
  output logic             available_pop,
  output logic [OUT_W-1:0] data_out,
  output logic             err_unexp,
  output logic             err_underflow
`ifdef ACC_FETCH_STATS_EN
  ,
  output logic [31:0]      pop_count
`endif
);

  localparam int RATIO = IN_W / OUT_W;
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW    = $clog2(DEPTH + 1);
  localparam int SW    = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam int TW    = CW + 2;

  logic [IN_W-1:0] buf_q [DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   occ_q, occ_d, outs_q, outs_d, drain_q, drain_d;
  logic [SW-1:0]   sel_q, sel_d;
  logic            req_q, req_d;
  logic            eu_q, eu_d, ef_q, ef_d;

  logic            resp_drain, resp_wr, resp_err, pop_ok, rel_e;
  logic [CW-1:0]   occ_n, outs_n, drain_n;
  logic [TW-1:0]   inflight;
  logic [IN_W-1:0] rd_word;

  always_comb begin
    resp_drain = data_valid && (drain_q != '0);
    resp_wr    = data_valid && (drain_q == '0) && (outs_q != '0);
    resp_err   = data_valid && (drain_q == '0) && (outs_q == '0);
    pop_ok     = pop_data && (occ_q != '0);
    rel_e      = pop_ok && (sel_q == SW'(RATIO - 1));

    occ_n   = occ_q + CW'(resp_wr) - CW'(rel_e);
    outs_n  = outs_q + CW'(req_q) - CW'(resp_wr);
    drain_n = drain_q - CW'(resp_drain);
    // Words still to be drained count as in flight so the total never exceeds DEPTH.
    inflight = TW'(occ_n) + TW'(outs_n) + TW'(drain_n);
    req_d    = en && available_read && !clear && (inflight < TW'(DEPTH));

    eu_d = eu_q | resp_err;
    ef_d = ef_q | (pop_data && (occ_q == '0));

    occ_d    = occ_n;
    outs_d   = outs_n;
    drain_d  = drain_n;
    wr_ptr_d = resp_wr ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = rel_e ? rd_ptr_q + PW'(1) : rd_ptr_q;
    sel_d    = sel_q;
    if (pop_ok) sel_d = rel_e ? '0 : sel_q + SW'(1);

    if (clear) begin
      occ_d    = '0;
      outs_d   = '0;
      drain_d  = drain_n + outs_n;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      sel_d    = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) buf_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      outs_q   <= '0;
      drain_q  <= '0;
      sel_q    <= '0;
      req_q    <= 1'b0;
      eu_q     <= 1'b0;
      ef_q     <= 1'b0;
    end else begin
      if (resp_wr) buf_q[wr_ptr_q] <= read_data;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
      outs_q   <= outs_d;
      drain_q  <= drain_d;
      sel_q    <= sel_d;
      req_q    <= req_d;
      eu_q     <= eu_d;
      ef_q     <= ef_d;
    end
  end

`ifdef ACC_FETCH_STATS_EN
  logic [31:0] pop_count_q, pop_count_d;

  always_comb begin
    pop_count_d = pop_count_q;
    if (clear)       pop_count_d = '0;
    else if (pop_ok) pop_count_d = pop_count_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) pop_count_q <= '0;
    else      pop_count_q <= pop_count_d;
  end

  assign pop_count = pop_count_q;
`endif

  assign rd_word       = buf_q[rd_ptr_q];
  assign data_out      = rd_word[sel_q*OUT_W +: OUT_W];
  assign request_read  = req_q;
  assign available_pop = (occ_q != '0);
  assign err_unexp     = eu_q;
  assign err_underflow = ef_q;

endmodule

// File: tb/tb_acc_fetch_stream.sv
// Directed bench for acc_fetch_stream: vector tables plus hand-written pop/clear/error sequences.
module tb_acc_fetch_stream;

  localparam int IN_W  = 512;
  localparam int OUT_W = 16;
  localparam int DEPTH = 4;

  logic             clk = 1'b0;
  logic             rst, en, clear, available_read, data_valid, pop_data;
  logic [IN_W-1:0]  read_data;
  logic             request_read, available_pop, err_unexp, err_underflow;
  logic [OUT_W-1:0] data_out;
`ifdef ACC_FETCH_STATS_EN
  logic [31:0]      pop_count;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  acc_fetch_stream #(.IN_W(IN_W), .OUT_W(OUT_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .en(en), .clear(clear), .available_read(available_read),
    .request_read(request_read), .data_valid(data_valid), .read_data(read_data),
    .pop_data(pop_data), .available_pop(available_pop), .data_out(data_out),
    .err_unexp(err_unexp), .err_underflow(err_underflow)
`ifdef ACC_FETCH_STATS_EN
    , .pop_count(pop_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        en, ar, dv, pop, clr;
    logic [15:0] tag;
    logic        req, av, cd;
    logic [15:0] dout;
    logic        eu, ef;
  } vec_t;

  vec_t tab[$];

  // Slice j of the wide word carries tag + j, so slice 0 is emitted first.
  function automatic logic [IN_W-1:0] mkword(input logic [15:0] tag);
    logic [IN_W-1:0] w;
    for (int j = 0; j < IN_W / 16; j++) w[j*16 +: 16] = tag + 16'(j);
    return w;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic e, ar, dv, p, c, input logic [15:0] tag);
    en = e; available_read = ar; data_valid = dv; pop_data = p; clear = c;
    read_data = mkword(tag);
  endtask

  task automatic step(input vec_t v, input int idx);
    drive(v.en, v.ar, v.dv, v.pop, v.clr, v.tag);
    @(negedge clk);
    chk($sformatf("v%0d.request_read", idx), 32'(request_read), 32'(v.req));
    chk($sformatf("v%0d.available_pop", idx), 32'(available_pop), 32'(v.av));
    chk($sformatf("v%0d.err_unexp", idx), 32'(err_unexp), 32'(v.eu));
    chk($sformatf("v%0d.err_underflow", idx), 32'(err_underflow), 32'(v.ef));
    if (v.cd) chk($sformatf("v%0d.data_out", idx), 32'(data_out), 32'(v.dout));
  endtask

  task automatic run_tab(input int base);
    for (int i = 0; i < tab.size(); i++) step(tab[i], base + i);
    tab.delete();
  endtask

  task automatic do_reset();
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 16'h0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  // Pops n words from the current entry, checking each word before it is taken.
  task automatic pop_words(input logic [15:0] first, input int n, input logic ar);
    for (int j = 0; j < n; j++) begin
      chk($sformatf("pop%0d.data_out", j), 32'(data_out), 32'(first + 16'(j)));
      chk($sformatf("pop%0d.available_pop", j), 32'(available_pop), 32'd1);
      drive(1, ar, 0, 1, 0, 16'h0);
      @(negedge clk);
    end
    drive(1, ar, 0, 0, 0, 16'h0);
  endtask

  initial begin
    @(negedge clk);
    do_reset();
    rst = 1'b0;
    #1;
    chk("rst.request_read", 32'(request_read), 32'd0);
    chk("rst.available_pop", 32'(available_pop), 32'd0);
    chk("rst.data_out", 32'(data_out), 32'd0);
    chk("rst.err_unexp", 32'(err_unexp), 32'd0);
    chk("rst.err_underflow", 32'(err_underflow), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // Four back-to-back requests, then the limiter holds; first response lands.
    //            en ar dv pop clr tag      req av cd dout     eu ef
    tab.push_back('{1, 1, 0, 0, 0, 16'h0,    1, 0, 1, 16'h0,    0, 0});
    tab.push_back('{1, 1, 0, 0, 0, 16'h0,    1, 0, 1, 16'h0,    0, 0});
    tab.push_back('{1, 1, 0, 0, 0, 16'h0,    1, 0, 1, 16'h0,    0, 0});
    tab.push_back('{1, 1, 0, 0, 0, 16'h0,    1, 0, 1, 16'h0,    0, 0});
    tab.push_back('{1, 1, 0, 0, 0, 16'h0,    0, 0, 1, 16'h0,    0, 0});
    tab.push_back('{1, 1, 0, 0, 0, 16'h0,    0, 0, 1, 16'h0,    0, 0});
    tab.push_back('{1, 1, 1, 0, 0, 16'h0001, 0, 1, 1, 16'h0001, 0, 0});
    run_tab(0);

    pop_words(16'h0001, 32, 1'b1);
    chk("drain1.available_pop", 32'(available_pop), 32'd0);
    chk("drain1.request_read", 32'(request_read), 32'd1);

    // Response and final pop of the previous entry in the same cycle.
    step('{1, 1, 1, 0, 0, 16'h0100, 0, 1, 1, 16'h0100, 0, 0}, 100);
    for (int j = 1; j < 32; j++) begin
      drive(1, 1, 0, 1, 0, 16'h0);
      @(negedge clk);
      chk($sformatf("e2pop%0d.data_out", j), 32'(data_out), 32'(16'h0100 + 16'(j)));
    end
    step('{1, 1, 1, 1, 0, 16'h0200, 1, 1, 1, 16'h0200, 0, 0}, 101);
    step('{1, 1, 0, 1, 0, 16'h0,    0, 1, 1, 16'h0201, 0, 0}, 102);

    // Clear with three outstanding, drain, then error flags.
    do_reset();
    tab.push_back('{1, 1, 0, 0, 0, 16'h0,    1, 0, 0, 16'h0,    0, 0});
    tab.push_back('{1, 1, 0, 0, 0, 16'h0,    1, 0, 0, 16'h0,    0, 0});
    tab.push_back('{1, 1, 0, 0, 0, 16'h0,    1, 0, 0, 16'h0,    0, 0});
    tab.push_back('{1, 0, 0, 0, 0, 16'h0,    0, 0, 0, 16'h0,    0, 0});
    tab.push_back('{1, 1, 0, 0, 1, 16'h0,    0, 0, 0, 16'h0,    0, 0});
    tab.push_back('{1, 0, 1, 0, 0, 16'h0A00, 0, 0, 0, 16'h0,    0, 0});
    tab.push_back('{1, 0, 1, 0, 0, 16'h0B00, 0, 0, 0, 16'h0,    0, 0});
    tab.push_back('{1, 0, 1, 0, 0, 16'h0C00, 0, 0, 0, 16'h0,    0, 0});
    tab.push_back('{1, 1, 0, 0, 0, 16'h0,    1, 0, 0, 16'h0,    0, 0});
    tab.push_back('{1, 0, 0, 0, 0, 16'h0,    0, 0, 0, 16'h0,    0, 0});
    tab.push_back('{1, 0, 1, 0, 0, 16'h0300, 0, 1, 1, 16'h0300, 0, 0});
    tab.push_back('{1, 0, 1, 0, 0, 16'h0400, 0, 1, 1, 16'h0300, 1, 0});
    run_tab(200);

    pop_words(16'h0300, 32, 1'b0);
    chk("drain2.available_pop", 32'(available_pop), 32'd0);
    step('{1, 0, 0, 1, 0, 16'h0, 0, 0, 0, 16'h0, 1, 1}, 300);
    step('{1, 0, 0, 0, 1, 16'h0, 0, 0, 0, 16'h0, 1, 1}, 301);
    step('{1, 0, 0, 0, 0, 16'h0, 0, 0, 0, 16'h0, 1, 1}, 302);
    rst = 1'b0;
    #1;
    chk("async_rst.err_unexp", 32'(err_unexp), 32'd0);
    chk("async_rst.err_underflow", 32'(err_underflow), 32'd0);
    @(negedge clk);
    rst = 1'b1;

`ifdef ACC_FETCH_STATS_EN
    do_reset();
    drive(1, 1, 0, 0, 0, 16'h0);
    repeat (5) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      drive(1, 0, 1, 0, 0, 16'h1000 * 16'(k + 1));
      @(negedge clk);
    end
    drive(1, 0, 0, 1, 0, 16'h0);
    repeat (70) @(negedge clk);
    drive(1, 0, 0, 0, 0, 16'h0);
    chk("stats.pop_count", pop_count, 32'd70);
    chk("stats.data_out", 32'(data_out), 32'(16'h3000 + 16'd6));
    drive(1, 0, 0, 0, 1, 16'h0);
    @(negedge clk);
    drive(1, 0, 0, 0, 0, 16'h0);
    chk("stats.cleared", pop_count, 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
